// File: rtl/clock_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : clock_gen_if
//  Purpose  : Bundles the control inputs and generated-clock outputs of
//             clock_gen so that the CPU-clock block is connected through a
//             single port.
//  Signals  : auto_mode  1      1 = free-run, 0 = manual single-step
//             halt       1      CPU request to stop the auto clock
//             m          1      raw step button (asynchronous, bouncy)
//             div        DIV_W  half-period select (half-period = div+1 clk)
//             cpu_clk    1      generated CPU clock
//             cpu_iclk   1      inverted CPU clock
//             rising     1      one-cycle pulse on first high cycle
//             running    1      high while free-running (RUN_H / RUN_L)
//  Modports : master - drives controls, observes clocks
//             slave  - the clock generator itself
//  Revision : 1.0  initial release
// ============================================================================
interface clock_gen_if #(
    parameter int DIV_W = 8
);
    logic             auto_mode;
    logic             halt;
    logic             m;
    logic [DIV_W-1:0] div;
    logic             cpu_clk;
    logic             cpu_iclk;
    logic             rising;
    logic             running;

    modport master (
        output auto_mode, halt, m, div,
        input  cpu_clk, cpu_iclk, rising, running
    );

    modport slave (
        input  auto_mode, halt, m, div,
        output cpu_clk, cpu_iclk, rising, running
    );
endinterface
`default_nettype wire

// File: rtl/clock_gen.sv
`default_nettype none
// ============================================================================
//  Module   : clock_gen
//  Purpose  : Programmable CPU clock generator. Derives cpu_clk from clk via
//             a half-period divider, with free-run, debounced single-step and
//             halt modes. A phase, once started, always runs to its full
//             latched length, so mode changes never create runt phases.
//  Ports    : clk   - master clock, all logic on its rising edge
//             rstn  - asynchronous active-low reset
//             bus   - clock_gen_if.slave (controls in, clocks out)
//  Params   : DIV_W    width of div
//             SCAN_DIV clk cycles per debounce sample tick (>=1)
//             DEB_LEN  equal consecutive samples to change level (>=1)
//  Revision : 1.0  initial release
// ============================================================================
module clock_gen #(
    parameter int DIV_W    = 8,
    parameter int SCAN_DIV = 4,
    parameter int DEB_LEN  = 2
) (
    input  logic          clk,
    input  logic          rstn,
    clock_gen_if.slave    bus
);

    localparam int c_SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {
        ST_STOP   = 2'd0,
        ST_RUN_H  = 2'd1,
        ST_RUN_L  = 2'd2,
        ST_STEP_H = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Button synchroniser and debouncer
    // ------------------------------------------------------------------
    logic [1:0]          r_m_sync;
    logic [c_SCAN_W-1:0] r_scan_cnt;
    logic [DEB_LEN-1:0]  r_deb_sh;
    logic                r_deb;
    logic                r_deb_q;
    logic                w_scan_tick;
    logic [DEB_LEN-1:0]  w_deb_shift;
    logic                w_step_req;

    assign w_scan_tick = (r_scan_cnt == c_SCAN_W'(SCAN_DIV - 1));

    generate
        if (DEB_LEN == 1) begin : g_deb_one
            assign w_deb_shift = r_m_sync[1];
        end else begin : g_deb_multi
            assign w_deb_shift = {r_deb_sh[DEB_LEN-2:0], r_m_sync[1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_m_sync   <= '0;
            r_scan_cnt <= '0;
            r_deb_sh   <= '0;
            r_deb      <= 1'b0;
            r_deb_q    <= 1'b0;
        end else begin
            r_m_sync <= {r_m_sync[0], bus.m};
            r_deb_q  <= r_deb;
            if (w_scan_tick) begin
                r_scan_cnt <= '0;
                r_deb_sh   <= w_deb_shift;
                // Level only moves once every sample in the window agrees;
                // a mixed window keeps the previous level.
                if (&w_deb_shift) begin
                    r_deb <= 1'b1;
                end else if (~|w_deb_shift) begin
                    r_deb <= 1'b0;
                end
            end else begin
                r_scan_cnt <= r_scan_cnt + c_SCAN_W'(1);
            end
        end
    end

    // One request per debounced press; holding the button adds nothing.
    assign w_step_req = r_deb & ~r_deb_q;

    // ------------------------------------------------------------------
    // Phase divider and clock FSM (all outputs registered)
    // ------------------------------------------------------------------
    state_t           r_state;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div_q;
    logic             r_cpu_clk;
    logic             r_cpu_iclk;
    logic             r_rising;
    logic             r_running;
    logic             w_phase_end;
    logic             w_auto_go;

    assign w_phase_end = (r_cnt == r_div_q);
    assign w_auto_go   = bus.auto_mode & ~bus.halt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_STOP;
            r_cnt      <= '0;
            r_div_q    <= '0;
            r_cpu_clk  <= 1'b0;
            r_cpu_iclk <= 1'b1;
            r_rising   <= 1'b0;
            r_running  <= 1'b0;
        end else begin
            r_rising <= 1'b0;
            case (r_state)
                ST_STOP: begin
                    r_cnt <= '0;
                    // Auto mode has priority over a coincident step request.
                    if (w_auto_go) begin
                        r_state    <= ST_RUN_H;
                        r_div_q    <= bus.div;
                        r_cpu_clk  <= 1'b1;
                        r_cpu_iclk <= 1'b0;
                        r_rising   <= 1'b1;
                        r_running  <= 1'b1;
                    end else if (!bus.auto_mode && w_step_req) begin
                        r_state    <= ST_STEP_H;
                        r_div_q    <= bus.div;
                        r_cpu_clk  <= 1'b1;
                        r_cpu_iclk <= 1'b0;
                        r_rising   <= 1'b1;
                        r_running  <= 1'b0;
                    end
                end
                ST_RUN_H: begin
                    // Controls are not sampled here so a high phase is never cut short.
                    if (w_phase_end) begin
                        r_state    <= ST_RUN_L;
                        r_cnt      <= '0;
                        r_div_q    <= bus.div;
                        r_cpu_clk  <= 1'b0;
                        r_cpu_iclk <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + DIV_W'(1);
                    end
                end
                ST_RUN_L: begin
                    if (w_phase_end) begin
                        r_cnt   <= '0;
                        r_div_q <= bus.div;
                        if (w_auto_go) begin
                            r_state    <= ST_RUN_H;
                            r_cpu_clk  <= 1'b1;
                            r_cpu_iclk <= 1'b0;
                            r_rising   <= 1'b1;
                        end else begin
                            r_state   <= ST_STOP;
                            r_running <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + DIV_W'(1);
                    end
                end
                ST_STEP_H: begin
                    // Step requests arriving here are dropped, not queued.
                    if (w_phase_end) begin
                        r_state    <= ST_STOP;
                        r_cnt      <= '0;
                        r_div_q    <= bus.div;
                        r_cpu_clk  <= 1'b0;
                        r_cpu_iclk <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + DIV_W'(1);
                    end
                end
                default: begin
                    r_state    <= ST_STOP;
                    r_cnt      <= '0;
                    r_cpu_clk  <= 1'b0;
                    r_cpu_iclk <= 1'b1;
                    r_running  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cpu_clk  = r_cpu_clk;
    assign bus.cpu_iclk = r_cpu_iclk;
    assign bus.rising   = r_rising;
    assign bus.running  = r_running;

endmodule
`default_nettype wire

// File: tb/tb_clock_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clock_gen
//  Purpose  : Directed self-checking bench for clock_gen. Inputs are driven
//             and outputs sampled on the falling edge of clk; cycle 0 of
//             each scenario is the first falling edge after the rising edge
//             that follows reset release.
//  Revision : 1.0  initial release
// ============================================================================
module tb_clock_gen;

    logic clk;
    logic rstn;
    int   errors;
    int   checks;

    clock_gen_if #(.DIV_W(8)) bus ();

    clock_gen #(
        .DIV_W    (8),
        .SCAN_DIV (4),
        .DEB_LEN  (2)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Hold reset two cycles with the given controls, release on a falling edge.
    task automatic do_reset(input logic auto_v, input logic halt_v, input logic [7:0] div_v);
        rstn          = 1'b0;
        bus.auto_mode = auto_v;
        bus.halt      = halt_v;
        bus.m         = 1'b0;
        bus.div       = div_v;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn          = 1'b0;
        bus.auto_mode = 1'b1;
        bus.halt      = 1'b0;
        bus.m         = 1'b0;
        bus.div       = 8'd2;
        repeat (3) @(negedge clk);
        checks++; if (bus.cpu_clk !== 1'b0) begin errors++; $display("FAIL reset_cpu_clk got=%b exp=0", bus.cpu_clk); end
        checks++; if (bus.cpu_iclk !== 1'b1) begin errors++; $display("FAIL reset_cpu_iclk got=%b exp=1", bus.cpu_iclk); end
        checks++; if (bus.rising !== 1'b0) begin errors++; $display("FAIL reset_rising got=%b exp=0", bus.rising); end
        checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL reset_running got=%b exp=0", bus.running); end
    endtask

    // div=2: 3 high / 3 low, rising on first high cycle of each period.
    task automatic test_auto_run();
        logic e_clk, e_rise;
        do_reset(1'b1, 1'b0, 8'd2);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            e_clk  = ((i % 6) < 3);
            e_rise = ((i % 6) == 0);
            checks++; if (bus.cpu_clk !== e_clk) begin errors++; $display("FAIL auto_clk cyc=%0d got=%b exp=%b", i, bus.cpu_clk, e_clk); end
            checks++; if (bus.cpu_iclk !== ~e_clk) begin errors++; $display("FAIL auto_iclk cyc=%0d got=%b exp=%b", i, bus.cpu_iclk, ~e_clk); end
            checks++; if (bus.rising !== e_rise) begin errors++; $display("FAIL auto_rising cyc=%0d got=%b exp=%b", i, bus.rising, e_rise); end
            checks++; if (bus.running !== 1'b1) begin errors++; $display("FAIL auto_running cyc=%0d got=%b exp=1", i, bus.running); end
        end
    endtask

    // div 2->0 during the first high phase: that phase keeps 3 cycles; the
    // low phase latches div at its start (0) so everything after is 1 cycle.
    task automatic test_div_change();
        logic e_clk, e_rise;
        do_reset(1'b1, 1'b0, 8'd2);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            e_clk  = (i < 3) ? 1'b1 : ((i % 2) == 0);
            e_rise = (i == 0) || (i >= 4 && (i % 2) == 0);
            checks++; if (bus.cpu_clk !== e_clk) begin errors++; $display("FAIL divchg_clk cyc=%0d got=%b exp=%b", i, bus.cpu_clk, e_clk); end
            checks++; if (bus.cpu_iclk !== ~e_clk) begin errors++; $display("FAIL divchg_iclk cyc=%0d got=%b exp=%b", i, bus.cpu_iclk, ~e_clk); end
            checks++; if (bus.rising !== e_rise) begin errors++; $display("FAIL divchg_rising cyc=%0d got=%b exp=%b", i, bus.rising, e_rise); end
            if (i == 0) bus.div = 8'd0;
        end
    endtask

    // div=1, halt raised in cycle 0 of the high phase, dropped in cycle 6.
    task automatic test_halt();
        logic [7:0] v_clk, v_run, v_rise;
        v_clk  = 8'b1100_0001;
        v_run  = 8'b1111_0001;
        v_rise = 8'b1000_0001;
        do_reset(1'b1, 1'b0, 8'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++; if (bus.cpu_clk !== v_clk[7-i]) begin errors++; $display("FAIL halt_clk cyc=%0d got=%b exp=%b", i, bus.cpu_clk, v_clk[7-i]); end
            checks++; if (bus.running !== v_run[7-i]) begin errors++; $display("FAIL halt_running cyc=%0d got=%b exp=%b", i, bus.running, v_run[7-i]); end
            checks++; if (bus.rising !== v_rise[7-i]) begin errors++; $display("FAIL halt_rising cyc=%0d got=%b exp=%b", i, bus.rising, v_rise[7-i]); end
            if (i == 0) bus.halt = 1'b1;
            if (i == 6) bus.halt = 1'b0;
        end
    endtask

    // Manual div=3: bouncy press then hold gives one 4-cycle pulse; a
    // release and re-press gives a second one.
    task automatic test_manual_step();
        int n_rise, hi_len, last_len, n_pulse;
        logic run_seen;
        do_reset(1'b0, 1'b0, 8'd3);
        for (int pass = 0; pass < 2; pass++) begin
            n_rise = 0; hi_len = 0; last_len = 0; n_pulse = 0; run_seen = 1'b0;
            for (int i = 0; i < 52; i++) begin
                @(negedge clk);
                if (bus.rising === 1'b1) n_rise++;
                if (bus.running !== 1'b0) run_seen = 1'b1;
                if (bus.cpu_clk === 1'b1) begin
                    hi_len++;
                end else if (hi_len != 0) begin
                    last_len = hi_len;
                    hi_len   = 0;
                    n_pulse++;
                end
                bus.m = (pass == 0 && i < 12) ? ~bus.m : 1'b1;
            end
            checks++; if (n_rise !== 1) begin errors++; $display("FAIL step_rise_count pass=%0d got=%0d exp=1", pass, n_rise); end
            checks++; if (n_pulse !== 1) begin errors++; $display("FAIL step_pulse_count pass=%0d got=%0d exp=1", pass, n_pulse); end
            checks++; if (last_len !== 4) begin errors++; $display("FAIL step_pulse_len pass=%0d got=%0d exp=4", pass, last_len); end
            checks++; if (run_seen !== 1'b0) begin errors++; $display("FAIL step_running pass=%0d got=%b exp=0", pass, run_seen); end
            checks++; if (bus.cpu_clk !== 1'b0) begin errors++; $display("FAIL step_end_clk pass=%0d got=%b exp=0", pass, bus.cpu_clk); end
            if (pass == 0) begin
                // Release long enough for the debounced level to drop.
                bus.m  = 1'b0;
                n_rise = 0;
                for (int i = 0; i < 30; i++) begin
                    @(negedge clk);
                    if (bus.rising === 1'b1) n_rise++;
                end
                checks++; if (n_rise !== 0) begin errors++; $display("FAIL step_release_rise got=%0d exp=0", n_rise); end
            end
        end
    endtask

    // div=4, auto_mode dropped at cnt=1 of the high phase.
    task automatic test_auto_drop();
        logic e_clk, e_run, e_rise;
        do_reset(1'b1, 1'b0, 8'd4);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            e_clk  = (i < 5);
            e_run  = (i < 10);
            e_rise = (i == 0);
            checks++; if (bus.cpu_clk !== e_clk) begin errors++; $display("FAIL drop_clk cyc=%0d got=%b exp=%b", i, bus.cpu_clk, e_clk); end
            checks++; if (bus.running !== e_run) begin errors++; $display("FAIL drop_running cyc=%0d got=%b exp=%b", i, bus.running, e_run); end
            checks++; if (bus.rising !== e_rise) begin errors++; $display("FAIL drop_rising cyc=%0d got=%b exp=%b", i, bus.rising, e_rise); end
            if (i == 1) bus.auto_mode = 1'b0;
        end
    endtask

    // Asynchronous reset in the middle of a high phase, then restart.
    task automatic test_async_reset();
        logic e_clk;
        do_reset(1'b1, 1'b0, 8'd2);
        repeat (2) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        checks++; if (bus.cpu_clk !== 1'b0) begin errors++; $display("FAIL areset_clk got=%b exp=0", bus.cpu_clk); end
        checks++; if (bus.cpu_iclk !== 1'b1) begin errors++; $display("FAIL areset_iclk got=%b exp=1", bus.cpu_iclk); end
        checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL areset_running got=%b exp=0", bus.running); end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            e_clk = (i < 3);
            checks++; if (bus.cpu_clk !== e_clk) begin errors++; $display("FAIL restart_clk cyc=%0d got=%b exp=%b", i, bus.cpu_clk, e_clk); end
            checks++; if (bus.rising !== (i == 0)) begin errors++; $display("FAIL restart_rising cyc=%0d got=%b exp=%b", i, bus.rising, (i == 0)); end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_auto_run();
        test_div_change();
        test_halt();
        test_manual_step();
        test_auto_drop();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
